// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES-128 core arbiter.
package aes_arb_pkg;

    localparam int AES_BLOCK_W  = 128;
    localparam int AES_CORE_LAT = 30;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/aes_128_arbiter_if.sv
// Requester, response and core-control bundle for aes_128_arbiter.
// master = arbiter side, slave = requesters plus AES core.
interface aes_128_arbiter_if #(
    parameter int NREQ = 4
) ();
    import aes_arb_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ*AES_BLOCK_W-1:0] req_data;
    logic [NREQ*AES_BLOCK_W-1:0] req_key;
    logic                        core_in_en;
    logic [AES_BLOCK_W-1:0]      core_data;
    logic [AES_BLOCK_W-1:0]      core_key;
    logic                        core_kill;
    logic                        core_out_en;
    logic [AES_BLOCK_W-1:0]      core_result;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0]             rsp_ready;
    logic [AES_BLOCK_W-1:0]      rsp_data;
    logic                        rsp_err;

    modport master (
        input  req_valid, req_data, req_key, core_out_en, core_result, rsp_ready,
        output req_ready, core_in_en, core_data, core_key, core_kill,
               rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_data, req_key, core_out_en, core_result, rsp_ready,
        input  req_ready, core_in_en, core_data, core_key, core_kill,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1,
// wrapping modulo NREQ.
module aes_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);
    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back to last+1 so the nearest one wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = |req;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end
endmodule

// File: rtl/aes_128_arbiter.sv
// Round-robin scheduler sharing one non-pipelined AES-128 core among NREQ requesters.
// Optional WAIT watchdog compiled in with `define AES_ARB_WATCHDOG_EN.
module aes_128_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              kill,
    aes_128_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NREQ);

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [IDX_W-1:0]       tag_reg, tag_next;
    logic [AES_BLOCK_W-1:0] core_data_reg, core_data_next;
    logic [AES_BLOCK_W-1:0] core_key_reg, core_key_next;
    logic [AES_BLOCK_W-1:0] rsp_data_reg, rsp_data_next;
    logic                   rsp_err_reg, rsp_err_next;

    logic [IDX_W-1:0]       grant;
    logic                   any_valid;
    logic                   accept;
    logic                   timeout_hit;
    logic                   wd_abort;
    logic [AES_BLOCK_W-1:0] req_data_arr [NREQ];
    logic [AES_BLOCK_W-1:0] req_key_arr  [NREQ];

    aes_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (bus.req_valid),
        .last      (last_reg),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // A request is only offered while idle and not being reset.
    assign accept = (state_reg == IDLE) && any_valid && !kill;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
            assign req_data_arr[gi]  = bus.req_data[AES_BLOCK_W*gi +: AES_BLOCK_W];
            assign req_key_arr[gi]   = bus.req_key[AES_BLOCK_W*gi +: AES_BLOCK_W];
            assign bus.req_ready[gi] = accept && (grant == IDX_W'(gi));
            assign bus.rsp_valid[gi] = (state_reg == RESP) && (tag_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef AES_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt_reg;

    // Held at zero outside WAIT, so it restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (kill || state_reg != WAIT) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 8'd1;
        end
    end

    assign timeout_hit = (state_reg == WAIT) && (wd_cnt_reg == WD_LIMIT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (kill) begin
            state_reg     <= IDLE;
            last_reg      <= IDX_W'(NREQ - 1);
            tag_reg       <= '0;
            core_data_reg <= '0;
            core_key_reg  <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            tag_reg       <= tag_next;
            core_data_reg <= core_data_next;
            core_key_reg  <= core_key_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        tag_next       = tag_reg;
        core_data_next = core_data_reg;
        core_key_next  = core_key_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        wd_abort       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    core_data_next = req_data_arr[grant];
                    core_key_next  = req_key_arr[grant];
                    tag_next       = grant;
                    last_next      = grant;
                    state_next     = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle takes precedence over the abort.
                if (bus.core_out_en) begin
                    rsp_data_next = bus.core_result;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else if (timeout_hit) begin
                    wd_abort      = 1'b1;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[tag_reg]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.core_in_en = (state_reg == LAUNCH);
    assign bus.core_data  = core_data_reg;
    assign bus.core_key   = core_key_reg;
    assign bus.core_kill  = kill | wd_abort;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_aes_128_arbiter.sv
// Self-checking bench for aes_128_arbiter: timestamp-based transaction model, core model,
// directed scenarios (reset, single block, kill, fairness, backpressure, optional watchdog).
module tb_aes_128_arbiter;
    import aes_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 40;
    localparam int W       = AES_BLOCK_W;
    localparam int IW      = $clog2(NREQ);

    localparam logic [W-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic kill;
    always #5 clk = ~clk;

    aes_128_arbiter_if #(.NREQ(NREQ)) bus ();

    aes_128_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .kill (kill),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Bench-side record of what each requester presents.
    logic [W-1:0] slot_d [NREQ];
    logic [W-1:0] slot_k [NREQ];
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign bus.req_data[W*gi +: W] = slot_d[gi];
        assign bus.req_key[W*gi +: W]  = slot_k[gi];
    end

    function automatic logic [W-1:0] cipher(input logic [W-1:0] d, input logic [W-1:0] k);
        if (d == PT && k == KEY) return CT;
        return d ^ k;
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[IW'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r;
        r = '0;
        if (i >= 0) r[IW'(i)] = 1'b1;
        return r;
    endfunction

    // ---------------- AES core stand-in ----------------
    int core_lat   = AES_CORE_LAT;
    bit core_never = 1'b0;

    initial begin
        bit           pend;
        bit           fire;
        int           due;
        logic [W-1:0] res;
        pend = 1'b0;
        due  = 0;
        bus.core_out_en = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clk);
            if (bus.core_kill) pend = 1'b0;
            else if (bus.core_in_en) begin
                pend = 1'b1;
                due  = cyc + core_lat;
            end
            fire = pend && !core_never && (cyc + 1 == due);
            res  = cipher(bus.core_data, bus.core_key);
            @(posedge clk);
            #1;
            bus.core_out_en = fire;
            bus.core_result = fire ? res : {4{32'hDEADBEEF}};
            if (fire) pend = 1'b0;
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    bit           m_busy = 1'b0;
    bit           m_rsp  = 1'b0;
    int           m_hs   = 0;
    int           m_tag  = 0;
    int           m_last = NREQ - 1;
    logic [W-1:0] m_cdata = '0;
    logic [W-1:0] m_ckey  = '0;
    logic [W-1:0] m_rdata = '0;
    logic         m_rerr  = 1'b0;

    int           g_req [$];
    int           g_cyc [$];
    int           r_tag [$];
    int           r_cyc [$];
    int           r_hs  [$];
    logic [W-1:0] r_data [$];
    logic         r_err  [$];

    int in_en_cnt   = 0;
    int rsp_v_cnt   = 0;
    int wd_kill_cnt = 0;

    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic            exp_ckill;
        if (bus.core_in_en) in_en_cnt++;
        if (bus.rsp_valid != '0) rsp_v_cnt++;
        if (bus.core_kill && !kill) wd_kill_cnt++;

        if (kill) begin
            check_int("ready_in_kill", int'(bus.req_ready), 0);
            check_int("core_kill_in_kill", int'(bus.core_kill), 1);
            m_busy  = 1'b0;
            m_rsp   = 1'b0;
            m_last  = NREQ - 1;
            m_cdata = '0;
            m_ckey  = '0;
            m_rdata = '0;
            m_rerr  = 1'b0;
        end else begin
            g         = m_busy ? -1 : rr_next(bus.req_valid, m_last);
            exp_ready = onehot(g);
            exp_ckill = 1'b0;
`ifdef AES_ARB_WATCHDOG_EN
            exp_ckill = m_busy && !m_rsp && (cyc == m_hs + TIMEOUT + 1) && !bus.core_out_en;
`endif
            check_int("req_ready", int'(bus.req_ready), int'(exp_ready));
            check_int("core_in_en", int'(bus.core_in_en), int'(m_busy && cyc == m_hs + 1));
            check("core_data", bus.core_data, m_cdata);
            check("core_key", bus.core_key, m_ckey);
            check_int("core_kill", int'(bus.core_kill), int'(exp_ckill));
            check_int("rsp_valid", int'(bus.rsp_valid), int'(m_rsp ? onehot(m_tag) : '0));
            check("rsp_data", bus.rsp_data, m_rdata);
            check_int("rsp_err", int'(bus.rsp_err), int'(m_rerr));

            if (g >= 0) begin
                m_busy  = 1'b1;
                m_hs    = cyc;
                m_tag   = g;
                m_last  = g;
                m_cdata = slot_d[IW'(g)];
                m_ckey  = slot_k[IW'(g)];
                g_req.push_back(g);
                g_cyc.push_back(cyc);
            end else if (m_busy && !m_rsp && cyc >= m_hs + 2) begin
                if (bus.core_out_en) begin
                    m_rsp   = 1'b1;
                    m_rdata = bus.core_result;
                    m_rerr  = 1'b0;
                end else if (exp_ckill) begin
                    m_rsp   = 1'b1;
                    m_rdata = '0;
                    m_rerr  = 1'b1;
                end
            end else if (m_rsp && bus.rsp_ready[IW'(m_tag)]) begin
                r_tag.push_back(m_tag);
                r_cyc.push_back(cyc);
                r_hs.push_back(m_hs);
                r_data.push_back(m_rdata);
                r_err.push_back(m_rerr);
                $display("rsp: req=%0d hs=%0d done=%0d err=%0d data=%h", m_tag, m_hs, cyc, m_rerr, m_rdata);
                m_busy = 1'b0;
                m_rsp  = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (g_req.size() < n && t < budget) begin tick(); t++; end
        check_int("wait_grants", int'(g_req.size() >= n), 1);
    endtask

    task automatic wait_resps(input int n, input int budget);
        int t = 0;
        while (r_tag.size() < n && t < budget) begin tick(); t++; end
        check_int("wait_resps", int'(r_tag.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (m_busy && t < budget) begin tick(); t++; end
        check_int("wait_idle", int'(m_busy), 0);
    endtask

    function automatic logic [W-1:0] gen_d(input int i);
        return {4{32'hDA7A_0000 + i}};
    endfunction

    function automatic logic [W-1:0] gen_k(input int i);
        return {4{32'hC0DE_0000 + i}};
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base_in;
        int base_rsp;
        int base_r;
        int base_k;
        int hs;
        int t;
        for (int i = 0; i < NREQ; i++) begin
            slot_d[i] = gen_d(i);
            slot_k[i] = gen_k(i);
        end
        kill          = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '1;

        // Reset: two kill cycles with everyone requesting.
        tick();
        check_int("reset_ctrl", int'({bus.req_ready, bus.rsp_valid, bus.core_in_en, bus.rsp_err}), 0);
        check("reset_core_data", bus.core_data, '0);
        check("reset_core_key", bus.core_key, '0);
        check("reset_rsp_data", bus.rsp_data, '0);
        tick();
        kill = 1'b0;
        wait_grants(1, 10);
        bus.req_valid = '0;
        check_int("first_grant", g_req[0], 0);
        wait_resps(1, 60);
        wait_idle(10);

        // Single block from requester 2 with the FIPS-197 vector.
        slot_d[2] = PT;
        slot_k[2] = KEY;
        base_in   = in_en_cnt;
        bus.req_valid = 4'b0100;
        wait_grants(2, 10);
        bus.req_valid = '0;
        wait_resps(2, 60);
        check_int("single_tag", r_tag[1], 2);
        check("single_ct", r_data[1], CT);
        check_int("single_err", int'(r_err[1]), 0);
        check_int("single_latency", r_cyc[1] - r_hs[1], 32);
        check_int("single_in_en_pulses", in_en_cnt - base_in, 1);
        wait_idle(10);

        // Kill ten cycles after a handshake from requester 2.
        slot_d[2] = gen_d(2);
        slot_k[2] = gen_k(2);
        bus.req_valid = 4'b0100;
        wait_grants(3, 10);
        bus.req_valid = '0;
        hs = g_cyc[2];
        t  = 0;
        while (cyc < hs + 10 && t < 20) begin tick(); t++; end
        kill     = 1'b1;
        base_rsp = rsp_v_cnt;
        base_r   = r_tag.size();
        #1;
        check_int("kill_core_kill", int'(bus.core_kill), 1);
        tick();
        kill = 1'b0;
        tick(40);
        check_int("kill_no_rsp_valid", rsp_v_cnt - base_rsp, 0);
        check_int("kill_no_rsp_log", r_tag.size() - base_r, 0);

        // Fairness: all valid for eight grants, order restarts at 0.
        bus.req_valid = '1;
        wait_grants(11, 8 * 40 + 20);
        bus.req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            check_int($sformatf("fair_grant%0d", i), g_req[3 + i], i % NREQ);
            if (i > 0)
                check_int($sformatf("fair_gap%0d", i), int'(g_cyc[3 + i] - g_cyc[2 + i] >= 33), 1);
        end
        wait_resps(10, 60);
        wait_idle(10);

        // Backpressure on requester 1; others valid and other rsp_ready bits high.
        slot_d[1] = {32{4'h1}};
        slot_k[1] = {32{4'h2}};
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b0010;
        wait_grants(12, 10);
        bus.req_valid = '1;
        t = 0;
        while (bus.rsp_valid == '0 && t < 60) begin tick(); t++; end
        check_int("bp_rsp_arrived", int'(bus.rsp_valid != '0), 1);
        for (int i = 0; i < 20; i++) begin
            check_int("bp_rsp_valid", int'(bus.rsp_valid), 4'b0010);
            check("bp_rsp_data", bus.rsp_data, {32{4'h3}});
            check_int("bp_req_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.rsp_ready = '1;
        bus.req_valid = '0;
        wait_resps(11, 10);
        check_int("bp_tag", r_tag[10], 1);
        check("bp_data", r_data[10], {32{4'h3}});
        wait_idle(10);

`ifdef AES_ARB_WATCHDOG_EN
        // Core never answers: abort with an error response.
        core_never    = 1'b1;
        base_k        = wd_kill_cnt;
        bus.req_valid = 4'b1000;
        wait_grants(13, 10);
        bus.req_valid = '0;
        wait_resps(12, 80);
        check_int("wd_err", int'(r_err[11]), 1);
        check("wd_data", r_data[11], '0);
        check_int("wd_latency", r_cyc[11] - r_hs[11], TIMEOUT + 2);
        check_int("wd_kill_pulses", wd_kill_cnt - base_k, 1);
        wait_idle(10);

        // Result lands exactly on the timeout cycle: result wins.
        core_never    = 1'b0;
        core_lat      = TIMEOUT;
        base_k        = wd_kill_cnt;
        bus.req_valid = 4'b1000;
        wait_grants(14, 10);
        bus.req_valid = '0;
        wait_resps(13, 80);
        check_int("tie_err", int'(r_err[12]), 0);
        check("tie_data", r_data[12], 128'h1AA400001AA400001AA400001AA40000);
        check_int("tie_latency", r_cyc[12] - r_hs[12], TIMEOUT + 2);
        check_int("tie_kill_pulses", wd_kill_cnt - base_k, 0);
        wait_idle(10);
`else
        base_k = wd_kill_cnt;
        check_int("no_wd_kill_pulses", base_k, 0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_128_arbiter.md
# aes_128_arbiter

Round-robin scheduler that shares a single non-pipelined AES-128 core (30-cycle latency, one block in flight) between NREQ requesters. Accepts one request per valid/ready handshake, launches it on the core with a one-cycle start pulse, captures the core result and returns it to the originating requester. Sits between the requester ports and the AES core's `in_en`/`out_en`/`kill` controls.

## Interface
- NREQ, 4: number of requesters, 2..8
- TIMEOUT, 40: watchdog limit in cycles; used only with the watchdog compiled in
- clk  in  1  clock
- kill  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot accept; handshake when valid&ready at a clk edge
- req_data  in  NREQ*128  plaintext; requester i at [128*i +: 128]
- req_key  in  NREQ*128  key; same packing
- core_in_en  out  1  one-cycle start pulse to the core
- core_data  out  128  registered plaintext to the core
- core_key  out  128  registered key to the core
- core_kill  out  1  core reset
- core_out_en  in  1  one-cycle result-valid pulse from the core
- core_result  in  128  core ciphertext, valid with core_out_en
- rsp_valid  out  NREQ  one-hot response valid
- rsp_ready  in  NREQ  response accept
- rsp_data  out  128  ciphertext, shared by all requesters
- rsp_err  out  1  response is a watchdog abort

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: grant is the first set req_valid bit scanning upward from last+1, wrapping modulo NREQ. req_ready[grant] is driven combinationally from the current req_valid. On handshake: capture req_data/req_key into core_data/core_key, store tag=grant and last=grant, then go to LAUNCH. A requester dropping req_valid before the handshake is legal; the grant is re-evaluated every cycle.
- LAUNCH: core_in_en=1 for exactly one cycle, then WAIT.
- WAIT: on core_out_en, capture core_result into rsp_data, set rsp_err=0, then go to RESP.
- RESP: rsp_valid[tag]=1 and rsp_data/rsp_err are held stable until rsp_ready[tag]. When it arrives, go to IDLE. rsp_ready on other bits is ignored.
- req_ready is 0 outside IDLE. core_out_en outside WAIT is ignored.
- core_kill = kill OR watchdog abort pulse.
- kill (any state): state goes to IDLE and last goes to NREQ-1. All outputs are 0 the following cycle, including rsp_data and rsp_err. An in-flight request is discarded and gets no response.

## Timing
- Reset values: req_ready, core_in_en, core_data, core_key, rsp_valid, rsp_data and rsp_err are all 0. core_kill follows kill.
- Handshake at edge T gives core_in_en high during cycle T+1.
- With the nominal core, core_out_en arrives in cycle T+31 and rsp_valid rises in cycle T+32.
- If rsp_ready is already high, the response handshake happens at the end of cycle T+32. The earliest next req_ready is cycle T+33, giving a minimum of 33 cycles per block.
- After reset, requester 0 has top priority. With all requesters valid, grants go in order 0,1,…,NREQ-1,0.

## Configuration
- AES_ARB_WATCHDOG_EN defined:
  - On entering WAIT, an 8-bit counter clears and then increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without core_out_en: core_kill pulses 1 cycle, rsp_data=0, rsp_err=1, and the FSM goes to RESP.
  - If core_out_en and timeout fall in the same cycle, the result wins (rsp_err=0).
- Not defined: WAIT has no timeout, rsp_err is tied 0, and core_kill = kill.

## Structure
- Package aes_arb_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, RESP)
  - AES_BLOCK_W=128
  - AES_CORE_LAT=30
- One sub-module, aes_rr_pick: a combinational round-robin picker. Inputs are the req vector and last; outputs are the grant index and any_valid.

## Test plan
- Reset: assert kill 2 cycles with all req_valid=1 -> all outputs 0. The first grant after release goes to requester 0.
- Single request: requester 2 sends data 0x00112233445566778899aabbccddeeff with key 0x000102030405060708090a0b0c0d0e0f, and the core model returns 0x69c4e0d86a7b0430d8cdb78070b4c55a after 30 cycles.
  - core_in_en is a single pulse, 1 cycle after the handshake.
  - rsp_valid=4'b0100 in handshake+32 with that ciphertext.
- Fairness: all 4 requesters continuously valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with no grant closer than 33 cycles apart.
- Backpressure: hold rsp_ready[1]=0 for 20 cycles -> rsp_valid[1] and rsp_data stay stable, and req_ready stays 0 throughout.
- Kill mid-WAIT: assert kill at handshake+10 -> no rsp_valid follows, core_kill is high that cycle, and the next grant starts from requester 0.
- Watchdog (AES_ARB_WATCHDOG_EN, TIMEOUT=40): core model never returns -> core_kill pulses once, then rsp_valid is asserted with rsp_err=1 and rsp_data=0.
  - A second run with core_out_en on the timeout cycle gives rsp_err=0.
